// File: rtl/gate_vector_checker_if.sv
// Bus between the gate checker and whatever drives/observes it:
// start request, gate-under-test output, gate inputs and the result fields.
interface gate_vector_checker_if #(
  parameter int CW = 8
);
  logic            start;
  logic            y;
  logic            a;
  logic            b;
  logic            busy;
  logic            done;
  logic            pass;
  logic [3:0]      fail_mask;
  logic [4*CW-1:0] delays;
  logic [CW-1:0]   max_delay;

  modport master (
    output start, y,
    input  a, b, busy, done, pass, fail_mask, delays, max_delay
  );

  modport slave (
    input  start, y,
    output a, b, busy, done, pass, fail_mask, delays, max_delay
  );
endinterface

// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for one 2-input gate. Walks the four input
// vectors in Gray order, measures how many cycles the synchronized gate
// output needs to reach the truth-table value, and flags slots that time out.
module gate_vector_checker #(
  parameter logic [3:0] TRUTH    = 4'b0111,
  parameter int         CW       = 8,
  parameter int         MAX_WAIT = 200
) (
  input logic                  clk,
  input logic                  reset_L,
  gate_vector_checker_if.slave bus
);

  localparam logic [CW-1:0] MAX_WAIT_C = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic            sync_p0, sync_p1;
  logic [1:0]      idx, idx_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            a_r, a_nxt;
  logic            b_r, b_nxt;
  logic            busy_r, busy_nxt;
  logic            done_r, done_nxt;
  logic            pass_r, pass_nxt;
  logic [3:0]      fail_r, fail_nxt;
  logic [4*CW-1:0] delays_r, delays_nxt;
  logic [CW-1:0]   max_r, max_nxt;
  logic            match;
  logic            timeout;

  // Gray-order vector for a slot: 00, 01, 11, 10 so only one input toggles per step.
  function automatic logic [1:0] slot_vec(input logic [1:0] slot);
    case (slot)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // Largest of the four packed slot delays.
  function automatic logic [CW-1:0] max_of(input logic [4*CW-1:0] v);
    logic [CW-1:0] m;
    m = v[CW-1:0];
    for (int k = 1; k < 4; k++) begin
      if (v[k*CW +: CW] > m) m = v[k*CW +: CW];
    end
    return m;
  endfunction

  // Two-flop synchronizer for the asynchronous gate output.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= bus.y;
      sync_p1 <= sync_p0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_L) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state, slot sequencing and result accumulation.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    cnt_nxt    = cnt;
    a_nxt      = a_r;
    b_nxt      = b_r;
    busy_nxt   = busy_r;
    done_nxt   = 1'b0;
    pass_nxt   = pass_r;
    fail_nxt   = fail_r;
    delays_nxt = delays_r;
    max_nxt    = max_r;
    match      = (sync_p1 == TRUTH[{a_r, b_r}]);
    timeout    = (cnt == MAX_WAIT_C);

    case (state)
      IDLE: begin
        if (bus.start) begin
          fail_nxt       = 4'b0000;
          delays_nxt     = '0;
          max_nxt        = '0;
          pass_nxt       = 1'b0;
          {a_nxt, b_nxt} = slot_vec(2'd0);
          cnt_nxt        = '0;
          idx_nxt        = 2'd0;
          busy_nxt       = 1'b1;
          state_nxt      = WAIT;
        end
      end

      WAIT: begin
        if (match || timeout) begin
          // A match in the same cycle as the timeout still counts as a match.
          if (match) begin
            delays_nxt[int'(idx)*CW +: CW] = cnt;
          end else begin
            delays_nxt[int'(idx)*CW +: CW] = MAX_WAIT_C;
            fail_nxt[idx]                  = 1'b1;
          end
          if (idx == 2'd3) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (fail_nxt == 4'b0000);
            max_nxt   = max_of(delays_nxt);
          end else begin
            idx_nxt        = idx + 2'd1;
            {a_nxt, b_nxt} = slot_vec(idx + 2'd1);
            cnt_nxt        = '0;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        a_nxt     = 1'b0;
        b_nxt     = 1'b0;
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Registered slot index, counter, gate drive and result fields.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      idx      <= 2'd0;
      cnt      <= '0;
      a_r      <= 1'b0;
      b_r      <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      pass_r   <= 1'b0;
      fail_r   <= 4'b0000;
      delays_r <= '0;
      max_r    <= '0;
    end else begin
      idx      <= idx_nxt;
      cnt      <= cnt_nxt;
      a_r      <= a_nxt;
      b_r      <= b_nxt;
      busy_r   <= busy_nxt;
      done_r   <= done_nxt;
      pass_r   <= pass_nxt;
      fail_r   <= fail_nxt;
      delays_r <= delays_nxt;
      max_r    <= max_nxt;
    end
  end

  assign bus.a         = a_r;
  assign bus.b         = b_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.fail_mask = fail_r;
  assign bus.delays    = delays_r;
  assign bus.max_delay = max_r;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a clocked gate model with configurable
// function and lag drives y, and a slot-level reference model predicts delays,
// timeouts and the done latency for each run.
module tb_gate_vector_checker;

  localparam int         CW       = 8;
  localparam int         MAX_WAIT = 200;
  localparam logic [3:0] T_NAND   = 4'b0111;

  logic clk = 1'b0;
  logic reset_L;

  always #5 clk = ~clk;

  gate_vector_checker_if #(.CW(CW)) bus ();

  gate_vector_checker #(
    .TRUTH    (T_NAND),
    .CW       (CW),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Gate model: output follows gate[{a,b}] as it was `lag` clock periods ago.
  logic [3:0] gate = T_NAND;
  int         lag  = 0;
  logic [1:0] sh [8] = '{default: 2'b00};

  always @(posedge clk) begin
    #1;
    for (int i = 7; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = {bus.a, bus.b};
    bus.y = gate[sh[lag]];
  end

  int done_seen = 0;
  always @(negedge clk) if (bus.done) done_seen++;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Expected results of the most recent reference-model evaluation.
  int         exp_dl [4];
  logic [3:0] exp_fm;
  int         exp_max;
  int         exp_done;
  int         exp_t1;

  // Slot k is applied at edge t[k]; y_s seen at edge n is the gate output of
  // period n-3, which reflects the inputs of period n-3-lag.
  task automatic ref_model(input logic [3:0] g, input int d);
    logic [1:0] order [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int         t [4];
    int         p, dur, src;
    logic       ys, hit;
    logic [1:0] ab;
    t[0]    = 0;
    exp_fm  = 4'b0000;
    exp_max = 0;
    for (int k = 0; k < 4; k++) begin
      hit = 1'b0;
      dur = MAX_WAIT + 1;
      for (int j = 1; j <= MAX_WAIT + 1 && !hit; j++) begin
        p   = t[k] + j - 3 - d;
        src = -1;
        for (int s = 0; s <= k; s++) if (p >= t[s]) src = s;
        ab  = (src < 0) ? 2'b00 : order[src];
        ys  = g[ab];
        if (ys == T_NAND[order[k]]) begin
          hit       = 1'b1;
          exp_dl[k] = j - 1;
          dur       = j;
        end
      end
      if (!hit) begin
        exp_dl[k] = MAX_WAIT;
        exp_fm[k] = 1'b1;
      end
      if (exp_dl[k] > exp_max) exp_max = exp_dl[k];
      if (k < 3) t[k+1] = t[k] + dur;
      else       exp_done = t[k] + dur;
    end
    exp_t1 = t[1];
  endtask

  task automatic run_check(input string name, input logic [3:0] g, input int d, input bit poke);
    int got_edge;
    int d0;
    gate = g;
    lag  = d;
    repeat (16) @(negedge clk);
    ref_model(g, d);
    d0 = done_seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, " busy"}, 32'(bus.busy), 32'd1);
    got_edge = -1;
    for (int k = 1; k <= 1200; k++) begin
      bus.start = (poke && k == exp_t1 + 1);
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        got_edge = k;
        break;
      end
    end
    chk({name, " done_edge"}, 32'(got_edge), 32'(exp_done));
    chk({name, " pass"}, 32'(bus.pass), 32'(exp_fm == 4'b0000));
    chk({name, " fail_mask"}, 32'(bus.fail_mask), 32'(exp_fm));
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s delay%0d", name, k), 32'(bus.delays[k*CW +: CW]), 32'(exp_dl[k]));
    chk({name, " max_delay"}, 32'(bus.max_delay), 32'(exp_max));
    repeat (2) @(negedge clk);
    chk({name, " busy_after"}, 32'(bus.busy), 32'd0);
    chk({name, " done_count"}, 32'(done_seen - d0), 32'd1);
    chk({name, " pass_held"}, 32'(bus.pass), 32'(exp_fm == 4'b0000));
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " a"}, 32'(bus.a), 32'd0);
    chk({name, " b"}, 32'(bus.b), 32'd0);
    chk({name, " busy"}, 32'(bus.busy), 32'd0);
    chk({name, " done"}, 32'(bus.done), 32'd0);
    chk({name, " pass"}, 32'(bus.pass), 32'd0);
    chk({name, " fail_mask"}, 32'(bus.fail_mask), 32'd0);
    chk({name, " delays"}, 32'(bus.delays), 32'd0);
    chk({name, " max_delay"}, 32'(bus.max_delay), 32'd0);
  endtask

  initial begin
    logic [3:0] pool [6] = '{4'b0111, 4'b0001, 4'b1111, 4'b0000, 4'b0110, 4'b0111};
    logic [3:0] g;
    int         d0;
    reset_L   = 1'b0;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk_reset_state("reset");
    reset_L = 1'b1;

    run_check("nand_lag0", T_NAND, 0, 1'b0);
    run_check("nand_lag3", T_NAND, 3, 1'b0);
    run_check("tied1", 4'b1111, 0, 1'b0);
    run_check("and_gate", 4'b0001, 0, 1'b0);
    run_check("restart_ignored", T_NAND, 0, 1'b1);

    // Reset during slot2 WAIT aborts the run without a done pulse.
    gate = T_NAND;
    lag  = 0;
    repeat (16) @(negedge clk);
    d0 = done_seen;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    chk_reset_state("mid_reset");
    repeat (12) @(negedge clk);
    chk("mid_reset no_done", 32'(done_seen - d0), 32'd0);
    run_check("after_reset", T_NAND, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      g = pool[$urandom_range(0, 5)];
      if (r == 7) g = 4'($urandom);
      run_check($sformatf("rand%0d", r), g, $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
